digit_scan_controller: RTL and testbench
========================================

Name: digit_scan_controller

Overview:
- Sequential driver for the downstream 1-to-4 demultiplexer that fans out to four display digits/rows.
- Steps the 2-bit position select through positions 0..3 and gates enable and the data bit.
- Inserts blanking dead-time between positions to suppress ghosting.
- Applies a double-buffered per-position mask only at frame boundaries, so a frame is never torn.

Parameters:
- DWELL_CYCLES, 8: clock cycles each position is driven (enable high); legal range is 1 or more.
- BLANK_CYCLES, 2: clock cycles of blanking after each position (enable low); legal range is 1 or more.
- CNT_W, 16: width of the internal dwell/blank cycle counter; must hold max(DWELL_CYCLES, BLANK_CYCLES).

Ports:
- clock  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  high = scan continuously; low = stop at the next frame boundary.
- digit_mask  in  4  per-position data bit; bit i drives position i.
- mask_load  in  1  one-cycle strobe that captures digit_mask.
- select  out  2  position index, connects to the demux select.
- enable  out  1  demux enable; high only while a position is being driven.
- data_out  out  1  data bit, connects to the demux data input.
- frame_done  out  1  one-cycle pulse at each frame boundary.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset values, applied on the edge where reset=1 and overriding all other inputs:
  - state=IDLE; select=0; enable=0; data_out=0; frame_done=0; busy=0.
  - shadow mask=0; pending mask=0; pending flag=0; counter=0.
- All outputs are registered.
- States: IDLE, ACTIVE, BLANK.
- IDLE:
  - enable=0, data_out=0, select=0, busy=0.
  - mask_load=1 writes digit_mask straight into the shadow mask (no pending).
  - run=1 moves to ACTIVE on the next edge with select=0 and counter=0.
  - Latency: first enable-high cycle is 1 clock after run is sampled high.
- ACTIVE:
  - enable=1, data_out=shadow[select], busy=1.
  - Lasts exactly DWELL_CYCLES cycles, then moves to BLANK with select unchanged.
- BLANK:
  - enable=0, data_out=0, select holds.
  - Lasts exactly BLANK_CYCLES cycles.
  - On the last blank cycle with select<3: select increments and state returns to ACTIVE. run is ignored mid-frame, so a frame always completes.
  - On the last blank cycle with select=3 (frame boundary):
    - select wraps to 0.
    - frame_done=1 for exactly the following cycle.
    - The pending mask, if flagged, is copied to the shadow mask and the flag clears.
    - Next state is ACTIVE if run=1, otherwise IDLE.
- Mask loading outside IDLE:
  - mask_load=1 in ACTIVE or BLANK writes the pending mask and sets the flag; the last write before the boundary wins.
  - The shadow mask is never modified mid-frame.
  - mask_load on the boundary cycle itself: the new digit_mask is bypassed directly into the shadow mask and is used for the next frame.
- Frame period is 4*(DWELL_CYCLES+BLANK_CYCLES) cycles; with defaults, 40 cycles.
- enable and data_out are never high during BLANK or IDLE.
- select changes only while enable=0 (glitch-free for the demux).
- Reset asserted mid-frame: reset values on the next edge; the in-progress frame is discarded with no frame_done.

Test Plan:
1. Reset, mask_load with digit_mask=4'b1111 in IDLE, run=1 held (defaults):
   - enable high for cycles 1–8 (select=0), low for cycles 9–10, high for 11–18 (select=1), and so on.
   - frame_done pulses at cycle 41; select then returns to 0.
2. Load 4'b0101 in IDLE, then run:
   - data_out=1 during positions 0 and 2; data_out=0 during positions 1 and 3.
   - enable still pulses high for all four positions.
3. Mask 4'b0101 running; mask_load with 4'b1010 while select=1:
   - Positions 2–3 in the current frame still use 0101.
   - The next frame outputs data_out=1 only on positions 1 and 3.
4. Drop run while select=1:
   - Positions 2 and 3 are still scanned.
   - frame_done pulses, then state is IDLE with busy=0 and all outputs 0.
5. Assert reset during ACTIVE with select=2:
   - Next cycle: select=0, enable=0, busy=0, frame_done=0.
   - A subsequent run starts at select=0 with shadow mask 0 (data_out=0).
6. mask_load with 4'b0011 coincident with the frame-boundary blank cycle:
   - The next frame immediately shows data_out=1 on positions 0–1.
   - No one-frame delay.

Source files
------------

// File: rtl/digit_scan_controller.sv
// Scan sequencer for a 1-to-4 display demux: steps select through positions 0..3,
// inserts blanking between positions and swaps the per-position mask only at frame boundaries.
module digit_scan_controller #(
  parameter int DWELL_CYCLES = 8,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] digit_mask,
  input  logic       mask_load,
  output logic [1:0] select,
  output logic       enable,
  output logic       data_out,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0]       LAST_POS   = 2'd3;

  state_e           state_q, state_d;
  logic [1:0]       select_q, select_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       pend_q, pend_d;
  logic             pend_flag_q, pend_flag_d;
  logic             enable_q, enable_d;
  logic             data_q, data_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    select_d     = select_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    pend_flag_d  = pend_flag_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        select_d = 2'd0;
        cnt_d    = '0;
        // No frame in flight, so the mask can go live immediately.
        if (mask_load) shadow_d = digit_mask;
        if (run)       state_d  = ACTIVE;
      end

      ACTIVE: begin
        if (mask_load) begin
          pend_d      = digit_mask;
          pend_flag_d = 1'b1;
        end
        if (cnt_q == DWELL_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BLANK: begin
        if (cnt_q != BLANK_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (mask_load) begin
            pend_d      = digit_mask;
            pend_flag_d = 1'b1;
          end
        end else if (select_q != LAST_POS) begin
          cnt_d    = '0;
          select_d = select_q + 2'd1;
          state_d  = ACTIVE;
          if (mask_load) begin
            pend_d      = digit_mask;
            pend_flag_d = 1'b1;
          end
        end else begin
          // Frame boundary: a strobe arriving right now beats any pending mask.
          cnt_d        = '0;
          select_d     = 2'd0;
          frame_done_d = 1'b1;
          pend_flag_d  = 1'b0;
          if (mask_load)        shadow_d = digit_mask;
          else if (pend_flag_q) shadow_d = pend_q;
          state_d = run ? ACTIVE : IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        select_d = 2'd0;
        cnt_d    = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe.
    enable_d = (state_d == ACTIVE);
    data_d   = enable_d & shadow_d[select_d];
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the mask registers are reset too; a run straight after reset must
      // show a blank display rather than stale contents.
      state_q      <= IDLE;
      select_q     <= 2'd0;
      cnt_q        <= '0;
      shadow_q     <= 4'd0;
      pend_q       <= 4'd0;
      pend_flag_q  <= 1'b0;
      enable_q     <= 1'b0;
      data_q       <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      enable_q     <= enable_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign select     = select_q;
  assign enable     = enable_q;
  assign data_out   = data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Self-checking bench for digit_scan_controller: directed test-plan steps followed by
// random traffic, compared every cycle against a frame-time reference model.
module tb_digit_scan_controller;

  localparam int D      = 8;
  localparam int B      = 2;
  localparam int SLOT   = D + B;
  localparam int PERIOD = 4 * SLOT;

  logic       clock;
  logic       reset;
  logic       run;
  logic [3:0] digit_mask;
  logic       mask_load;
  logic [1:0] select;
  logic       enable;
  logic       data_out;
  logic       frame_done;
  logic       busy;

  digit_scan_controller #(
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .run(run),
    .digit_mask(digit_mask),
    .mask_load(mask_load),
    .select(select),
    .enable(enable),
    .data_out(data_out),
    .frame_done(frame_done),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Reference model: m_t is the cycle index within the current frame, -1 when idle.
  int         m_t      = -1;
  logic [3:0] m_shadow = 4'd0;
  logic [3:0] m_pend   = 4'd0;
  bit         m_pflag  = 1'b0;
  bit         m_fd     = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
      $error("%s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  function automatic bit exp_en();
    return (m_t >= 0) && ((m_t % SLOT) < D);
  endfunction

  function automatic int exp_sel();
    return (m_t >= 0) ? (m_t / SLOT) : 0;
  endfunction

  task automatic model_update(input logic r, input logic ld, input logic rst,
                              input logic [3:0] dm);
    if (rst) begin
      m_t = -1; m_shadow = 4'd0; m_pend = 4'd0; m_pflag = 1'b0; m_fd = 1'b0;
    end else if (m_t < 0) begin
      m_fd = 1'b0;
      if (ld) m_shadow = dm;
      if (r)  m_t = 0;
    end else if (m_t == PERIOD - 1) begin
      m_fd = 1'b1;
      if (ld)           m_shadow = dm;
      else if (m_pflag) m_shadow = m_pend;
      m_pflag = 1'b0;
      m_t = r ? 0 : -1;
    end else begin
      m_fd = 1'b0;
      if (ld) begin m_pend = dm; m_pflag = 1'b1; end
      m_t++;
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic rst, input logic [3:0] dm);
    int sel;
    run = r; mask_load = ld; reset = rst; digit_mask = dm;
    @(posedge clock);
    model_update(r, ld, rst, dm);
    #1;
    sel = exp_sel();
    chk("select",     int'(select),     sel);
    chk("enable",     int'(enable),     int'(exp_en()));
    chk("data_out",   int'(data_out),   int'(exp_en() && m_shadow[sel]));
    chk("frame_done", int'(frame_done), int'(m_fd));
    chk("busy",       int'(busy),       int'(m_t >= 0));
  endtask

  // Keeps stepping with run held until the model reaches the given position.
  task automatic run_to_pos(input int pos, input logic r);
    int budget = 2 * PERIOD;
    while (!((m_t >= 0) && (exp_sel() == pos) && exp_en()) && budget > 0) begin
      step(r, 1'b0, 1'b0, 4'd0);
      budget--;
    end
    chk("run_to_pos_timeout", int'(budget > 0), 1);
  endtask

  task automatic drain_to_idle();
    int budget = 2 * PERIOD;
    while (m_t >= 0 && budget > 0) begin
      step(1'b0, 1'b0, 1'b0, 4'd0);
      budget--;
    end
    chk("idle_timeout", int'(budget > 0), 1);
  endtask

  initial begin
    int c_data;
    int c_en;
    run = 1'b0; mask_load = 1'b0; reset = 1'b1; digit_mask = 4'd0;

    phase = "reset";
    step(1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'hF);

    phase = "t1_full_mask";
    step(1'b0, 1'b1, 1'b0, 4'b1111);
    for (int c = 1; c <= 41; c++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0);
      if (c == 1)  chk("c1_enable", int'(enable), 1);
      if (c == 9)  chk("c9_enable", int'(enable), 0);
      if (c == 11) chk("c11_select", int'(select), 1);
      if (c == 40) chk("c40_frame_done", int'(frame_done), 0);
      if (c == 41) begin
        chk("c41_frame_done", int'(frame_done), 1);
        chk("c41_select", int'(select), 0);
      end
    end
    drain_to_idle();

    phase = "t2_mask_0101";
    step(1'b0, 1'b1, 1'b0, 4'b0101);
    c_data = 0; c_en = 0;
    for (int c = 0; c < PERIOD; c++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0);
      c_data += int'(data_out);
      c_en   += int'(enable);
    end
    chk("data_cycles", c_data, 2 * D);
    chk("enable_cycles", c_en, 4 * D);

    phase = "t3_midframe_load";
    run_to_pos(1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'b1010);
    run_to_pos(0, 1'b1);
    c_data = 0;
    for (int c = 0; c < PERIOD; c++) begin
      if (data_out && (select == 2'd1 || select == 2'd3)) c_data++;
      step(1'b1, 1'b0, 1'b0, 4'd0);
    end
    chk("new_mask_data_cycles", c_data, 2 * D);

    phase = "t4_stop";
    run_to_pos(1, 1'b1);
    drain_to_idle();
    step(1'b0, 1'b0, 1'b0, 4'd0);
    chk("idle_busy", int'(busy), 0);

    phase = "t5_reset_midframe";
    run_to_pos(2, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4'd0);
    chk("after_reset_select", int'(select), 0);
    c_data = 0;
    for (int c = 0; c < PERIOD; c++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0);
      c_data += int'(data_out);
    end
    chk("zero_mask_data", c_data, 0);

    phase = "t6_boundary_load";
    begin
      int budget = 2 * PERIOD;
      while (m_t != PERIOD - 1 && budget > 0) begin
        step(1'b1, 1'b0, 1'b0, 4'd0);
        budget--;
      end
      chk("boundary_timeout", int'(budget > 0), 1);
    end
    step(1'b1, 1'b1, 1'b0, 4'b0011);
    chk("bypass_first_data", int'(data_out), 1);
    c_data = 1;
    for (int c = 1; c < PERIOD; c++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0);
      c_data += int'(data_out);
    end
    chk("bypass_data_cycles", c_data, 2 * D);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 199) == 0), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
